// File: rtl/rv32_mdu.sv
// Iterative RV32M multiply/divide unit writing straight into the register-file write port.
// Optional macro RV32_MDU_FAST_MUL_EN replaces the iterative multiply with a single-cycle one.
module rv32_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            wr,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] wrdata
);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          f3_q;
    logic [4:0]          rd_q;
    logic [5:0]          cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mcand_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     dvsr_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic [4:0]          rd_out_q;
    logic [XLEN-1:0]     wrdata_q;

    // Operand decode, only meaningful while idle
    logic            signed_a, signed_b, a_sgn, b_sgn;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        signed_a    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
        signed_b    = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
        a_sgn       = signed_a & a[XLEN-1];
        b_sgn       = signed_b & b[XLEN-1];
        mag_a       = a_sgn ? (~a + 1'b1) : a;
        mag_b       = b_sgn ? (~b + 1'b1) : b;
        div_zero    = funct3[2] && (b == '0);
        div_ovf     = funct3[2] && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}})
                      && (b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? a : '1;
        end else if (!funct3[1]) begin
            special_res = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

`ifdef RV32_MDU_FAST_MUL_EN
    // Sign-extended to full product width; the low 2*XLEN bits of the product are exact
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_a    = {{XLEN{signed_a & a[XLEN-1]}}, a};
        fast_b    = {{XLEN{signed_b & b[XLEN-1]}}, b};
        fast_prod = fast_a * fast_b;
        fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, dvsr_q};
        div_sub   = div_shift[XLEN-1:0] - dvsr_q;
        prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_res_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        if (!f3_q[2]) begin
            fix_res = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            fix_res = f3_q[1] ? rem_fix : quo_fix;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    if (special) begin
                        state_d = StDone;
                    end else if (!funct3[2]) begin
`ifdef RV32_MDU_FAST_MUL_EN
                        state_d = StDone;
`else
                        state_d = StMul;
`endif
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StMul, StDiv: if (cnt_q == 6'd31) state_d = StFix;
            StFix:        state_d = StDone;
            StDone:       state_d = StIdle;
            default:      state_d = StIdle;
        endcase
        if (flush && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_out_q  <= '0;
            wrdata_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !flush) begin
                        f3_q      <= funct3;
                        rd_q      <= rd;
                        cnt_q     <= '0;
                        neg_res_q <= a_sgn ^ b_sgn;
                        neg_rem_q <= a_sgn;
                        acc_q     <= {{XLEN{1'b0}}, mag_b};
                        mcand_q   <= mag_a;
                        rem_q     <= '0;
                        quo_q     <= mag_a;
                        dvsr_q    <= mag_b;
                        if (special) begin
                            wrdata_q <= special_res;
                            rd_out_q <= rd;
                        end
`ifdef RV32_MDU_FAST_MUL_EN
                        else if (!funct3[2]) begin
                            wrdata_q <= fast_res;
                            rd_out_q <= rd;
                        end
`endif
                    end
                end
                StMul: begin
                    acc_q <= {mul_sum, acc_q[XLEN-1:1]};
                    cnt_q <= (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
                end
                StDiv: begin
                    rem_q <= div_ge ? div_sub : div_shift[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], div_ge};
                    cnt_q <= (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
                end
                StFix: begin
                    if (!flush) begin
                        wrdata_q <= fix_res;
                        rd_out_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != StIdle);
    assign wr     = (state_q == StDone) && (rd_out_q != 5'd0) && !flush;
    assign rd_out = rd_out_q;
    assign wrdata = wrdata_q;

endmodule

// File: tb/tb_rv32_mdu.sv
// Self-checking bench for rv32_mdu: directed vector table, multi-cycle corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_rv32_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        busy, wr;
    logic [4:0]  rd_out;
    logic [31:0] wrdata;

    int checks = 0;
    int errors = 0;

`ifdef RV32_MDU_FAST_MUL_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    rv32_mdu #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .rd     (rd),
        .flush  (flush),
        .busy   (busy),
        .wr     (wr),
        .rd_out (rd_out),
        .wrdata (wrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x,
                                              input logic [31:0] y);
        logic [63:0] p;
        int sx, sy;
        bit ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'b001: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
            3'b010: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
            3'b011: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sx / sy;
            end
            3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                return sx % sy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] x,
                                   input logic [31:0] y);
        if (f3[2] && (y == 0)) return 1;
        if (f3[2] && !f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        if (!f3[2] && Fast) return 1;
        return 34;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Start is already driven high in the current cycle (cycle 0)
    task automatic wait_op(input int lat, input logic [4:0] rdv, input logic [31:0] exp,
                           input string name);
        int wr_cnt;
        wr_cnt = 0;
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (wr) wr_cnt++;
            if (cyc == lat) begin
                chk({name, " busy@wr"}, {31'b0, busy}, 32'd1);
                chk({name, " wr"}, {31'b0, wr}, {31'b0, rdv != 5'd0});
                if (rdv != 5'd0) begin
                    chk({name, " wrdata"}, wrdata, exp);
                    chk({name, " rd_out"}, {27'b0, rd_out}, {27'b0, rdv});
                end
            end
            if (cyc == lat + 1) chk({name, " busy_fall"}, {31'b0, busy}, 32'd0);
        end
        chk({name, " wr_count"}, wr_cnt, {31'b0, rdv != 5'd0});
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] rdv, input logic [31:0] exp, input string name);
        funct3 = f3;
        a      = av;
        b      = bv;
        rd     = rdv;
        start  = 1'b1;
        wait_op(exp_lat(f3, av, bv), rdv, exp, name);
    endtask

    initial begin
        logic [2:0]  seq_f3;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;
        int          wr_seen;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 5'd6,  32'h0000_0006};
        vecs[2]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD};
        vecs[3]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF};
        vecs[4]  = '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'h7FFF_FFFC};
        vecs[5]  = '{3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'h0000_0001};
        vecs[6]  = '{3'b100, 32'h0000_1234, 32'h0000_0000, 5'd11, 32'hFFFF_FFFF};
        vecs[7]  = '{3'b111, 32'h0000_1234, 32'h0000_0000, 5'd12, 32'h0000_1234};
        vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
        vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000};
        vecs[10] = '{3'b001, 32'hFFFF_FFF9, 32'h0000_0003, 5'd15, 32'hFFFF_FFFF};
        vecs[11] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset wr", {31'b0, wr}, 32'd0);
        chk("reset rd_out", {27'b0, rd_out}, 32'd0);
        chk("reset wrdata", wrdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            funct3 = vecs[i].f3;
            a      = vecs[i].a;
            b      = vecs[i].b;
            rd     = vecs[i].rd;
            start  = 1'b1;
            wait_op(exp_lat(vecs[i].f3, vecs[i].a, vecs[i].b), vecs[i].rd, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Flush of an iterative operation in cycle 10
        seq_f3 = Fast ? 3'b101 : 3'b010;
        funct3 = seq_f3;
        a      = 32'hFFFF_FFFF;
        b      = 32'hFFFF_FFFF;
        rd     = 5'd3;
        start  = 1'b1;
        wr_seen = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (wr) wr_seen++;
            if (cyc == 10) flush = 1'b1;
            if (cyc == 11) begin
                chk("flush busy", {31'b0, busy}, 32'd0);
                flush = 1'b0;
            end
        end
        chk("flush no wr", wr_seen, 32'd0);

        run_op(seq_f3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,
               ref_model(seq_f3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), "rd0 rerun");
        run_op(seq_f3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
               ref_model(seq_f3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), "rd3 rerun");

        // Start presented during DONE is ignored, then taken on the next IDLE cycle
        funct3 = 3'b100;
        a      = 32'h0000_0055;
        b      = 32'h0;
        rd     = 5'd4;
        start  = 1'b1;
        @(negedge clk);
        chk("done wr", {31'b0, wr}, 32'd1);
        funct3 = 3'b101;
        a      = 32'd50;
        b      = 32'd5;
        @(negedge clk);
        chk("start in done ignored", {31'b0, busy}, 32'd0);
        wait_op(34, 5'd4, 32'd10, "start after done");

        // Flush together with start in IDLE
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush+start busy", {31'b0, busy}, 32'd0);
        chk("flush+start wr", {31'b0, wr}, 32'd0);

        // Reset in cycle 20 of a DIV
        funct3 = 3'b100;
        a      = 32'd100;
        b      = 32'd7;
        rd     = 5'd9;
        start  = 1'b1;
        wr_seen = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (wr) wr_seen++;
        end
        rst = 1'b1;
        #1;
        chk("mid-reset busy", {31'b0, busy}, 32'd0);
        chk("mid-reset wr", {31'b0, wr}, 32'd0);
        chk("mid-reset rd_out", {27'b0, rd_out}, 32'd0);
        chk("mid-reset wrdata", wrdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (wr) wr_seen++;
        end
        chk("reset no wr", wr_seen, 32'd0);
        run_op(3'b100, 32'd100, 32'd7, 5'd9, 32'd14, "post-reset div");

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
                default: ;
            endcase
            rrd = 5'($urandom_range(0, 31));
            run_op(rf3, ra, rb, rrd, ref_model(rf3, ra, rb), $sformatf("rand%0d f3=%0d", i, rf3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_mdu.md
# rv32_mdu

Iterative RV32M multiply/divide unit in the execute stage, between register-file read and writeback. It takes the two source operands read for an M-extension instruction and computes the 32-bit result over several cycles. It then drives a one-cycle write request (`wr`, `rd_out`, `wrdata`) directly into the register-file write port. The decoder stalls issue while `busy` is high.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand (dividend / multiplicand).
- `b`  in  XLEN  rs2 operand (divisor / multiplier).
- `rd`  in  5  destination register index.
- `flush`  in  1  abort the in-flight operation with no write.
- `busy`  out  1  operation in flight (not IDLE).
- `wr`  out  1  register-file write enable, one-cycle pulse.
- `rd_out`  out  5  destination index, valid with `wr`.
- `wrdata`  out  XLEN  result, valid with `wr`.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- **IDLE**
  - On `start`, latch `funct3` and `rd`.
  - Latch operand magnitudes and result-sign flags:
    - signed view: MULH both operands; MULHSU `a` only; DIV/REM both.
    - unsigned view: MUL and MULHU (low word sign-independent), DIVU/REMU.
  - Go to MUL (`funct3[2]`=0) or DIV (`funct3[2]`=1).
- **Special cases go IDLE→DONE directly:**
  - Divide by zero (`b`=0): DIV/DIVU → 0xFFFFFFFF; REM/REMU → `a`.
  - Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- **MUL:** 32-iteration shift-add on a 64-bit unsigned accumulator, one multiplier bit per cycle (LSB first). A 6-bit counter exits at 31.
- **DIV:** 32-iteration restoring division, one quotient bit per cycle. Uses a 33-bit partial remainder.
- **FIX:** one cycle.
  - Two's-complement negate the product when the result sign is set.
  - Quotient sign = sign(`a`) XOR sign(`b`); remainder sign = sign(`a`).
  - Select the word: MUL low 32; MULH/MULHSU/MULHU high 32.
- **DONE:** `wr`=1 for exactly one cycle, then IDLE.
  - If `rd_out`=0, `wr` stays 0; the unit still passes through DONE.
- **`start` handling:**
  - Ignored while `busy`.
  - `start` in DONE is ignored; it is accepted on the following IDLE cycle.
- **`flush`:**
  - In any non-IDLE state, next state is IDLE and no `wr` is issued.
  - `flush` and `start` together in IDLE: `start` is ignored.
- `wrdata` and `rd_out` hold their last values outside DONE.

## Timing
- Reset values: `busy`=0, `wr`=0, `rd_out`=0, `wrdata`=0, state IDLE, counter 0.
- Asserting `rst` mid-operation discards all state immediately; no write is issued.
- Iterative path, with `start` high in cycle 0:
  - `busy`=1 in cycles 1–34.
  - MUL/DIV occupy cycles 1–32, FIX is cycle 33.
  - `wr`=1 in cycle 34, `busy`=0 in cycle 35.
  - Back-to-back: the next `start` may be presented in cycle 35.
- Special-case path: `wr`=1 and `busy`=1 in cycle 1.
- `flush` high in cycle k: `busy`=0 in cycle k+1.

## Configuration
- `RV32_MDU_FAST_MUL_EN` defined:
  - Multiplies use a single-cycle combinational 33×33 signed multiplier.
  - Sign extension depends on funct3; IDLE→DONE, with `wr` in cycle 1.
  - Division is unchanged.
- Undefined: multiplies use the iterative MUL/FIX path, with `wr` in cycle 34.

## Test plan
- MUL: `a`=7, `b`=0xFFFFFFFD, `rd`=5 → `wr` in cycle 34 (cycle 1 with macro), `rd_out`=5, `wrdata`=0xFFFFFFEB. MULHU with the same operands → 0x00000006.
- DIV: `a`=0xFFFFFFF9 (−7), `b`=2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU → 0x7FFFFFFC. REMU → 1.
- DIV by zero: `a`=0x1234, `b`=0 → DIV 0xFFFFFFFF in cycle 1. REMU → 0x1234 in cycle 1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM → 0. Both in cycle 1.
- MULHSU: `a`=0xFFFFFFFF, `b`=0xFFFFFFFF (iterative build):
  - `flush` in cycle 10 → `busy`=0 in cycle 11, no `wr`.
  - Rerun with `rd`=0 → no `wr`, `busy` falls in cycle 35.
  - Rerun with `rd`=3 → `wrdata`=0xFFFFFFFF.
- Reset: assert `rst` in cycle 20 of a DIV → all outputs 0 immediately, no `wr`. After release, `start` is accepted normally.
